// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - control/status bundle between mc_controller and the multi-cycle datapath
// Purpose: groups instruction fields, datapath status and all control strobes/selects.
// Ports (master = controller side):
//   in : op[5:0], funct[5:0], zero, mem_ready
//   out: pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//        ALUSrcA, ALUSrcB[1:0], ALUControl[2:0], PCSource[1:0], instr_done, state[3:0]
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_en;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSource;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSource, instr_done, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSource, instr_done, state
  );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control unit (Moore FSM + ALU function decode)
// Purpose: sequences a shared-memory multi-cycle datapath through fetch, decode and
//          per-class execute/writeback states, stalling on mem_ready in memory states.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  mc_controller_if.master: op/funct/zero/mem_ready in, control strobes,
//        mux selects, instr_done and state out
module mc_controller (
  input  logic           clk,
  input  logic           rst,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t st;

  // Unknown funct codes fall back to add.
  function automatic logic [2:0] alu_decode(input logic [5:0] fn);
    case (fn)
      6'b100000: alu_decode = ALU_ADD;
      6'b100010: alu_decode = ALU_SUB;
      6'b100100: alu_decode = ALU_AND;
      6'b100101: alu_decode = ALU_OR;
      6'b101010: alu_decode = ALU_SLT;
      default:   alu_decode = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= FETCH;
    end else begin
      case (st)
        FETCH:   if (bus.mem_ready) st <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: st <= MEMADR;
            OP_RTYPE:     st <= EXECUTE;
            OP_BEQ:       st <= BRANCH;
            OP_ADDI:      st <= ADDIEX;
            OP_J:         st <= JUMP;
            default:      st <= FETCH;
          endcase
        end
        MEMADR:  st <= (bus.op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   if (bus.mem_ready) st <= MEMWB;
        MEMWR:   if (bus.mem_ready) st <= FETCH;
        EXECUTE: st <= ALUWB;
        ADDIEX:  st <= ADDIWB;
        default: st <= FETCH;
      endcase
    end
  end

  logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, done;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_control;

  always_comb begin
    pc_write    = 1'b0;
    branch      = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    pc_source   = 2'b00;
    done        = 1'b0;
    case (st)
      FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        // PC+4 and the IR are only captured once the read actually completes.
        ir_write    = bus.mem_ready;
        pc_write    = bus.mem_ready;
      end
      DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done      = bus.mem_ready;
      end
      EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = alu_decode(bus.funct);
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        done      = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        branch      = 1'b1;
        pc_source   = 2'b01;
        done        = 1'b1;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset holds the FSM in FETCH, so selects already show FETCH values; only the
  // side-effecting strobes need gating to stop writes while rst is high.
  assign bus.pc_en      = ~rst & (pc_write | (branch & bus.zero));
  assign bus.MemRead    = ~rst & mem_read;
  assign bus.MemWrite   = ~rst & mem_write;
  assign bus.IRWrite    = ~rst & ir_write;
  assign bus.RegWrite   = ~rst & reg_write;
  assign bus.instr_done = ~rst & done;
  assign bus.IorD       = iord;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.PCSource   = pc_source;
  assign bus.state      = st;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - self-checking bench for mc_controller
module tb_mc_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mc_controller_if bus();

  mc_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
    logic [1:0] pcsrc;
    logic       done;
  } outs_t;

  typedef struct {
    int st;
    bit mr;
    bit z;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         z;
    int         wf;
    int         wm;
    int         cyc;
    int         dn;
    int         pe;
    int         rw;
    int         mw;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_ADDI || op == OP_J;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic outs_t actual_outs();
    outs_t o;
    o.pc_en    = bus.pc_en;
    o.iord     = bus.IorD;
    o.memread  = bus.MemRead;
    o.memwrite = bus.MemWrite;
    o.irwrite  = bus.IRWrite;
    o.regdst   = bus.RegDst;
    o.memtoreg = bus.MemtoReg;
    o.regwrite = bus.RegWrite;
    o.alusrca  = bus.ALUSrcA;
    o.alusrcb  = bus.ALUSrcB;
    o.aluctl   = bus.ALUControl;
    o.pcsrc    = bus.PCSource;
    o.done     = bus.instr_done;
    return o;
  endfunction

  // What each phase of an instruction drives onto the datapath.
  function automatic outs_t expect_outs(input int st, input bit mr, input bit z, input logic [5:0] fn);
    outs_t o = '0;
    case (st)
      0:  begin o.memread = 1; o.alusrcb = 2'b01; o.aluctl = 3'b010; o.irwrite = mr; o.pc_en = mr; end
      1:  begin o.alusrcb = 2'b11; o.aluctl = 3'b010; end
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluctl = 3'b010; end
      3:  begin o.memread = 1; o.iord = 1; end
      4:  begin o.regwrite = 1; o.memtoreg = 1; o.done = 1; end
      5:  begin o.memwrite = 1; o.iord = 1; o.done = mr; end
      6:  begin o.alusrca = 1; o.aluctl = alu_ref(fn); end
      7:  begin o.regwrite = 1; o.regdst = 1; o.done = 1; end
      8:  begin o.alusrca = 1; o.aluctl = 3'b110; o.pcsrc = 2'b01; o.done = 1; o.pc_en = z; end
      9:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluctl = 3'b010; end
      10: begin o.regwrite = 1; o.done = 1; end
      11: begin o.pc_en = 1; o.pcsrc = 2'b10; o.done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Reference model: the phase list of an instruction class, with each memory
  // phase stretched by its wait count, driven cycle by cycle and compared.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
    int   seq[$];
    cyc_t plan[$];
    int   dones = 0;
    outs_t a, e;
    seq = '{0, 1};
    case (op)
      OP_LW:   begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      OP_SW:   begin seq.push_back(2); seq.push_back(5); end
      OP_R:    begin seq.push_back(6); seq.push_back(7); end
      OP_BEQ:  seq.push_back(8);
      OP_ADDI: begin seq.push_back(9); seq.push_back(10); end
      OP_J:    seq.push_back(11);
      default: ;
    endcase
    foreach (seq[k]) begin
      if (seq[k] == 0 || seq[k] == 3 || seq[k] == 5) begin
        int w = (seq[k] == 0) ? wf : wm;
        for (int j = 0; j < w; j++) plan.push_back('{seq[k], 1'b0, 1'($urandom)});
        plan.push_back('{seq[k], 1'b1, 1'($urandom)});
      end else begin
        plan.push_back('{seq[k], 1'($urandom), 1'($urandom)});
      end
    end
    bus.op    = op;
    bus.funct = fn;
    foreach (plan[k]) begin
      bus.mem_ready = plan[k].mr;
      bus.zero      = plan[k].z;
      @(negedge clk);
      chk($sformatf("state op=%0h cyc=%0d", op, k), 32'(bus.state), 32'(plan[k].st));
      a = actual_outs();
      e = expect_outs(plan[k].st, plan[k].mr, plan[k].z, fn);
      chk($sformatf("outs op=%0h st=%0d", op, plan[k].st), {15'd0, a}, {15'd0, e});
      if (bus.instr_done) dones++;
      @(posedge clk);
      #1;
    end
    chk($sformatf("done_count op=%0h", op), 32'(dones), is_legal(op) ? 32'd1 : 32'd0);
  endtask

  // Table entry: run one instruction, stretching FETCH by wf and MEMRD/MEMWR by wm cycles.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, dn = 0, pe = 0, rw = 0, mw = 0, fw = v.wf, mwt = v.wm;
    bit left = 0, fin = 0, mr;
    bus.op    = v.op;
    bus.funct = v.fn;
    bus.zero  = v.z;
    while (!fin && cyc < 30) begin
      if (bus.state == 4'd0) begin
        mr = (fw == 0);
        if (fw > 0) fw--;
      end else if (bus.state == 4'd3 || bus.state == 4'd5) begin
        mr = (mwt == 0);
        if (mwt > 0) mwt--;
      end else begin
        mr = 1'b1;
      end
      bus.mem_ready = mr;
      @(negedge clk);
      dn += int'(bus.instr_done);
      pe += int'(bus.pc_en);
      rw += int'(bus.RegWrite);
      mw += int'(bus.MemWrite & mr);
      @(posedge clk);
      #1;
      cyc++;
      if (bus.state != 4'd0) left = 1;
      else if (left) fin = 1;
    end
    chk($sformatf("vec%0d cycles", idx), 32'(cyc), 32'(v.cyc));
    chk($sformatf("vec%0d instr_done", idx), 32'(dn), 32'(v.dn));
    chk($sformatf("vec%0d pc_en", idx), 32'(pe), 32'(v.pe));
    chk($sformatf("vec%0d RegWrite", idx), 32'(rw), 32'(v.rw));
    chk($sformatf("vec%0d MemWrite", idx), 32'(mw), 32'(v.mw));
  endtask

  task automatic beq_hand(input bit z);
    bus.op = OP_BEQ; bus.funct = 6'h00; bus.mem_ready = 1'b1; bus.zero = z;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("beq state", 32'(bus.state), 32'd8);
    chk("beq pc_en", 32'(bus.pc_en), 32'(z));
    chk("beq PCSource", 32'(bus.PCSource), 32'd1);
    @(posedge clk); #1;
    chk("beq back to fetch", 32'(bus.state), 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{OP_R,    6'h20, 1'b0, 0, 0, 4, 1, 1, 1, 0};
    vecs[1]  = '{OP_R,    6'h22, 1'b0, 0, 0, 4, 1, 1, 1, 0};
    vecs[2]  = '{OP_LW,   6'h00, 1'b0, 0, 2, 7, 1, 1, 1, 0};
    vecs[3]  = '{OP_LW,   6'h00, 1'b0, 1, 0, 6, 1, 1, 1, 0};
    vecs[4]  = '{OP_SW,   6'h00, 1'b0, 0, 0, 4, 1, 1, 0, 1};
    vecs[5]  = '{OP_SW,   6'h00, 1'b0, 0, 1, 5, 1, 1, 0, 1};
    vecs[6]  = '{OP_ADDI, 6'h00, 1'b0, 0, 0, 4, 1, 1, 1, 0};
    vecs[7]  = '{OP_BEQ,  6'h00, 1'b1, 0, 0, 3, 1, 2, 0, 0};
    vecs[8]  = '{OP_BEQ,  6'h00, 1'b0, 0, 0, 3, 1, 1, 0, 0};
    vecs[9]  = '{OP_J,    6'h00, 1'b0, 0, 0, 3, 1, 2, 0, 0};
    vecs[10] = '{6'h3f,   6'h00, 1'b0, 0, 0, 2, 0, 1, 0, 0};
    vecs[11] = '{6'h3f,   6'h00, 1'b0, 2, 0, 4, 0, 1, 0, 0};

    bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    // Asynchronous reset between clock edges.
    #1 rst = 1'b1;
    #1;
    chk("reset state", 32'(bus.state), 32'd0);
    chk("reset MemRead", 32'(bus.MemRead), 32'd0);
    chk("reset pc_en", 32'(bus.pc_en), 32'd0);
    chk("reset ALUSrcB", 32'(bus.ALUSrcB), 32'd1);
    chk("reset ALUControl", 32'(bus.ALUControl), 32'd2);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset MemRead", 32'(bus.MemRead), 32'd1);
    @(posedge clk); #1;
    chk("fetch holds without ready", 32'(bus.state), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Directed sequences through the reference model.
    run_instr(OP_R, 6'h22, 0, 0);
    run_instr(OP_LW, 6'h00, 0, 2);
    run_instr(OP_SW, 6'h00, 0, 1);
    run_instr(OP_ADDI, 6'h00, 0, 0);
    run_instr(OP_J, 6'h00, 0, 0);
    run_instr(6'h3f, 6'h00, 0, 0);

    beq_hand(1'b1);
    beq_hand(1'b0);

    // Reset asserted mid-MEMRD while the read completes: nothing may be written.
    bus.op = OP_LW; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reach MEMRD", 32'(bus.state), 32'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset state", 32'(bus.state), 32'd0);
    chk("reset RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("reset MemWrite", 32'(bus.MemWrite), 32'd0);
    chk("reset IRWrite", 32'(bus.IRWrite), 32'd0);
    @(posedge clk); #1;
    chk("held reset state", 32'(bus.state), 32'd0);
    chk("held reset RegWrite", 32'(bus.RegWrite), 32'd0);
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("release state", 32'(bus.state), 32'd0);
    chk("release MemRead", 32'(bus.MemRead), 32'd1);
    @(posedge clk); #1;

    // Randomized instruction stream against the model.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op, fn;
      logic [5:0] fns[5];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      case ($urandom_range(0, 6))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        default: begin
          op = 6'($urandom);
          if (is_legal(op)) op = 6'h3f;
        end
      endcase
      fn = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle MIPS control unit that sequences a shared datapath (single memory for instructions and data, one ALU, IR, A/B/ALUOut/MDR registers) over several clock cycles per instruction. It replaces the single-cycle decoder pair with a Moore FSM plus an ALU-function decode. It sits beside the multi-cycle datapath and supports memory wait states through a ready input.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  6  opcode from IR (IR[31:26])
- funct  in  6  function field from IR (IR[5:0])
- zero  in  1  ALU zero flag (valid in BRANCH state)
- mem_ready  in  1  memory access complete this cycle
- pc_en  out  1  PC load enable = PCWrite | (Branch & zero)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg  out  1  write data select: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse on the commit cycle of each instruction
- state  out  4  current state encoding (debug/verification)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12–15 go to FETCH next cycle with all enables 0.
- Unlisted outputs are 0 in each state; mux selects default to 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSource=00; IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; to DECODE when 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next by op: 100011/101011 → MEMADR, 000000 → EXECUTE, 000100 → BRANCH, 001000 → ADDIEX, 000010 → JUMP, anything else → FETCH (no writes, instr_done=0).
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. lw → MEMRD, sw → MEMWR.
- MEMRD: MemRead=1, IorD=1; waits on mem_ready; → MEMWB when ready.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1 → FETCH.
- MEMWR: MemWrite=1, IorD=1; held until mem_ready; instr_done=mem_ready; → FETCH when ready.
- EXECUTE: ALUSrcA=1, ALUSrcB=00; ALUControl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other → add. → ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, Branch=1, PCSource=01, instr_done=1 → FETCH. pc_en=zero.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add → ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 → FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1 → FETCH.
- op is sampled only in DECODE and MEMADR; funct only in EXECUTE (IR stable after FETCH).

## Timing
- Reset: state=FETCH immediately on rst rising edge, regardless of clk. While rst=1, MemRead, MemWrite, IRWrite, pc_en, RegWrite, instr_done are forced 0; selects hold FETCH values. The first fetch read is issued in the first cycle after rst deasserts.
- Reset mid-instruction aborts it: no register, PC, or memory write occurs after rst asserts.
- Cycles with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2. Each cycle with mem_ready=0 in FETCH, MEMRD, or MEMWR adds one cycle.
- Write enables are combinational from state (and mem_ready where noted) and must be valid before the clock edge that commits them. No output depends on zero except pc_en.
- instr_done is high exactly once per completed instruction; never in FETCH or DECODE.

## Test plan
- Reset: assert rst mid-MEMRD with mem_ready=1 → state=0 asynchronously, RegWrite=0, no writes; after release, FETCH with MemRead=1.
- R-type sub (op=000000, funct=100010), mem_ready=1 → states 0,1,6,7,0; ALUControl=110 in EXECUTE; RegWrite=1, RegDst=1 in ALUWB; instr_done pulses once.
- lw with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0 (7 cycles); MemtoReg=1, RegWrite=1 only in MEMWB.
- beq: zero=1 → pc_en=1, PCSource=01 in BRANCH; zero=0 → pc_en=0; 3 cycles each.
- sw, addi, j back-to-back → MemWrite=1 in MEMWR only when mem_ready=1; ADDIWB has RegDst=0; JUMP has pc_en=1, PCSource=10.
- Illegal op=111111 → states 0,1,0; all write enables 0 in DECODE and instr_done never asserts.
